// File: rtl/apb_pkg.sv
// Shared APB constants, master FSM state encoding and the PSEL decode helper.
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int PSEL_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    function automatic logic [PSEL_W-1:0] psel_onehot(input logic [SEL_W-1:0] idx);
        logic [PSEL_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index,
// which is held in r_ptr and updated only when the grant is consumed.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_upd,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_gnt_idx,
    output logic               o_gnt_any
);

    logic [PTR_W-1:0] r_ptr;

    always_comb begin
        int               k;
        logic [PTR_W-1:0] w_idx;
        k         = 0;
        w_idx     = '0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        // i = NUM_REQ wraps back to r_ptr itself, so it is checked last
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = int'(r_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            w_idx = PTR_W'(k);
            if (!o_gnt_any && i_req[w_idx]) begin
                o_gnt_any    = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_upd && o_gnt_any) begin
            r_ptr <= o_gnt_idx;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Multi-requester APB master: round-robin request arbitration, slave select
// decode, SETUP/ACCESS sequencing and a PREADY timeout.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int NUM_SLV     = 16,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][APB_AW-1:0] req_addr,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0][APB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [APB_DW-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic [APB_AW-1:0]              PADDR,
    output logic [APB_DW-1:0]              PWDATA,
    output logic                           PWRITE,
    output logic [PSEL_W-1:0]              PSEL,
    output logic                           PENABLE,
    input  logic [APB_DW-1:0]              PRDATA,
    input  logic                           PREADY
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SEL_W:0]   NUM_SLV_L = NUM_SLV[SEL_W:0];
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    apb_state_e r_state;
    apb_state_e w_state_nxt;

    logic [NUM_REQ-1:0] w_gnt;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;

    logic               w_accept;
    logic               w_term;
    logic               w_tmo;
    logic [APB_AW-1:0]  w_sel_addr;
    logic [SEL_W-1:0]   w_sel_idx;
    logic               w_dec_ok;

    logic [PTR_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [APB_AW-1:0]  r_paddr;
    logic [APB_DW-1:0]  r_pwdata;
    logic               r_pwrite;
    logic [PSEL_W-1:0]  r_psel;
    logic               r_penable;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_rsp_err;
    logic [APB_DW-1:0]  r_rsp_rdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETn),
        .i_req     (req_valid),
        .i_upd     (w_accept),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    // Request handshake: a transfer is taken on a rising edge where
    // req_valid[i] & req_ready[i]; ready is offered only in IDLE, to the
    // round-robin winner, combinationally from req_valid and the pointer.
    assign req_ready  = (r_state == ST_IDLE) ? w_gnt : '0;

    assign w_sel_addr = req_addr[w_gnt_idx];
    assign w_sel_idx  = w_sel_addr[SEL_LSB +: SEL_W];
    assign w_dec_ok   = ({1'b0, w_sel_idx} < NUM_SLV_L);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_term      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_any) begin
                    w_accept = 1'b1;
                    // decode errors are answered straight from IDLE
                    if (w_dec_ok) begin
                        w_state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY wins over the terminal count
                if (PREADY) begin
                    w_term      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == CNT_LAST) begin
                    w_term      = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_owner     <= '0;
            r_wait_cnt  <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;

            if (w_accept) begin
                r_owner  <= w_gnt_idx;
                r_paddr  <= w_sel_addr;
                r_pwdata <= req_wdata[w_gnt_idx];
                r_pwrite <= req_write[w_gnt_idx];
                r_psel   <= w_dec_ok ? psel_onehot(w_sel_idx) : '0;
                if (!w_dec_ok) begin
                    r_rsp_valid[w_gnt_idx] <= 1'b1;
                    r_rsp_err              <= 1'b1;
                end
            end

            if (r_state == ST_SETUP) begin
                r_penable <= 1'b1;
            end

            if (r_state == ST_ACCESS && !w_term) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_term) begin
                r_psel               <= '0;
                r_penable            <= 1'b0;
                r_rsp_valid[r_owner] <= 1'b1;
                r_rsp_err            <= w_tmo;
                r_rsp_rdata          <= (!w_tmo && !r_pwrite) ? PRDATA : '0;
            end
        end
    end

    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: a table of single transfers plus
// hand-written timeout, terminal-count, dropped-request and reset sequences.
module tb_apb_master_arb;

    logic              PCLK;
    logic              PRESETn;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        req_write;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE;
    logic [15:0]       PSEL;
    logic              PENABLE;
    logic [31:0]       PRDATA;
    logic              PREADY;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic [1:0]  exp_ready;
        logic [15:0] exp_psel;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    apb_master_arb #(
        .NUM_REQ     (2),
        .NUM_SLV     (12),
        .SEL_LSB     (12),
        .TIMEOUT_CYC (256)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and apply the bus-wide invariants.
    task automatic tick();
        @(negedge PCLK);
        if (PRESETn) begin
            chk("psel_known", 32'($isunknown(PSEL)), 32'd0);
            chk("psel_onehot0", 32'($onehot0(PSEL)), 32'd1);
            chk("penable_needs_psel", 32'(PENABLE && (PSEL == 16'h0)), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, 32'(PSEL), 32'd0);
        chk({tag, "_penable"}, 32'(PENABLE), 32'd0);
        chk({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
        chk({tag, "_paddr"}, PADDR, 32'd0);
        chk({tag, "_pwdata"}, PWDATA, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int          owner;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        owner   = v.exp_ready[1] ? 1 : 0;
        e_addr  = (owner == 1) ? v.addr + 32'h10 : v.addr;
        e_wdata = (owner == 1) ? ~v.wdata : v.wdata;

        req_addr[0]  = v.addr;
        req_addr[1]  = v.addr + 32'h10;
        req_wdata[0] = v.wdata;
        req_wdata[1] = ~v.wdata;
        req_write    = {2{v.write}};
        req_valid    = v.valid;
        PRDATA       = v.prdata;
        PREADY       = 1'b0;
        #1 chk("req_ready_grant", 32'(req_ready), 32'(v.exp_ready));

        tick();
        req_valid = v.valid & ~v.exp_ready;

        if (v.exp_err) begin
            chk("dec_rsp_valid", 32'(rsp_valid), 32'(v.exp_ready));
            chk("dec_rsp_err", 32'(rsp_err), 32'd1);
            chk("dec_rsp_rdata", rsp_rdata, 32'd0);
            chk("dec_psel", 32'(PSEL), 32'd0);
            chk("dec_penable", 32'(PENABLE), 32'd0);
            req_valid = 2'b00;
            tick();
            chk("dec_rsp_clear", 32'(rsp_valid), 32'd0);
            return;
        end

        chk("setup_psel", 32'(PSEL), 32'(v.exp_psel));
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_paddr", PADDR, e_addr);
        chk("setup_pwrite", 32'(PWRITE), 32'(v.write));
        chk("setup_pwdata", PWDATA, e_wdata);
        chk("setup_req_ready", 32'(req_ready), 32'd0);
        chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);

        for (int n = 0; n <= v.waits; n++) begin
            tick();
            chk("access_penable", 32'(PENABLE), 32'd1);
            chk("access_psel", 32'(PSEL), 32'(v.exp_psel));
            chk("access_paddr", PADDR, e_addr);
            chk("access_pwrite", 32'(PWRITE), 32'(v.write));
            chk("access_pwdata", PWDATA, e_wdata);
            chk("access_req_ready", 32'(req_ready), 32'd0);
            chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
            PREADY = (n == v.waits);
        end

        tick();
        PREADY    = 1'b0;
        req_valid = 2'b00;
        chk("rsp_valid", 32'(rsp_valid), 32'(v.exp_ready));
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("done_psel", 32'(PSEL), 32'd0);
        chk("done_penable", 32'(PENABLE), 32'd0);
        tick();
        chk("rsp_clear", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int          cnt;
        logic [31:0] rd;

        // requester 1 always sees addr+0x10 and ~wdata, so a wrong mux is visible
        vecs[0] = '{valid:2'b01, write:1'b1, addr:32'h0000_3004, wdata:32'hDEAD_BEEF, prdata:32'hFFFF_0000,
                    waits:0, exp_ready:2'b01, exp_psel:16'h0008, exp_err:1'b0, exp_rdata:32'h0};
        vecs[1] = '{valid:2'b10, write:1'b0, addr:32'h0000_1000, wdata:32'h0000_0000, prdata:32'h1234_5678,
                    waits:3, exp_ready:2'b10, exp_psel:16'h0002, exp_err:1'b0, exp_rdata:32'h1234_5678};
        vecs[2] = '{valid:2'b11, write:1'b1, addr:32'h0000_5000, wdata:32'h0BAD_F00D, prdata:32'hFFFF_0000,
                    waits:0, exp_ready:2'b01, exp_psel:16'h0020, exp_err:1'b0, exp_rdata:32'h0};
        vecs[3] = '{valid:2'b11, write:1'b0, addr:32'h0000_B008, wdata:32'h0000_0000, prdata:32'hA5A5_0F0F,
                    waits:1, exp_ready:2'b10, exp_psel:16'h0800, exp_err:1'b0, exp_rdata:32'hA5A5_0F0F};
        vecs[4] = '{valid:2'b11, write:1'b0, addr:32'h0000_0000, wdata:32'h0000_0000, prdata:32'h0000_FFFF,
                    waits:0, exp_ready:2'b01, exp_psel:16'h0001, exp_err:1'b0, exp_rdata:32'h0000_FFFF};
        vecs[5] = '{valid:2'b11, write:1'b1, addr:32'h0000_7F00, wdata:32'h1357_9BDF, prdata:32'hFFFF_0000,
                    waits:2, exp_ready:2'b10, exp_psel:16'h0080, exp_err:1'b0, exp_rdata:32'h0};
        vecs[6] = '{valid:2'b01, write:1'b1, addr:32'h0000_C000, wdata:32'h0000_00AA, prdata:32'hFFFF_0000,
                    waits:0, exp_ready:2'b01, exp_psel:16'h0000, exp_err:1'b1, exp_rdata:32'h0};
        vecs[7] = '{valid:2'b11, write:1'b0, addr:32'h0000_F123, wdata:32'h0000_0000, prdata:32'hFFFF_0000,
                    waits:0, exp_ready:2'b10, exp_psel:16'h0000, exp_err:1'b1, exp_rdata:32'h0};

        PRESETn   = 1'b0;
        req_valid = 2'b00;
        req_addr  = '0;
        req_write = 2'b00;
        req_wdata = '0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        #3 chk_all_zero("reset");
        tick();
        tick();
        PRESETn = 1'b1;
        tick();
        chk_all_zero("post_reset");
        chk("post_reset_ready", 32'(req_ready), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // A request raised while busy and withdrawn before IDLE leaves no trace.
        req_addr[0]  = 32'h0000_6000;
        req_addr[1]  = 32'h0000_9000;
        req_wdata[0] = 32'h6666_0000;
        req_wdata[1] = 32'h9999_0000;
        req_write    = 2'b11;
        req_valid    = 2'b01;
        PREADY       = 1'b0;
        #1 chk("drop_grant0", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b10;
        PREADY    = 1'b1;
        #1 chk("drop_busy_ready", 32'(req_ready), 32'd0);
        tick();
        chk("drop_access_penable", 32'(PENABLE), 32'd1);
        req_valid = 2'b00;
        tick();
        PREADY = 1'b0;
        chk("drop_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
            chk("drop_no_psel", 32'(PSEL), 32'd0);
            chk("drop_paddr_kept", PADDR, 32'h0000_6000);
        end

        // Timeout: PREADY never rises, abort after exactly 256 ACCESS cycles.
        req_addr[0] = 32'h0000_2000;
        req_write   = 2'b00;
        req_valid   = 2'b01;
        PRDATA      = 32'h1111_2222;
        PREADY      = 1'b0;
        tick();
        req_valid = 2'b00;
        chk("tmo_setup_psel", 32'(PSEL), 32'h0004);
        cnt = 0;
        for (int g = 0; g < 400; g++) begin
            tick();
            if (rsp_valid != 2'b00) break;
            if (PENABLE) cnt++;
        end
        chk("tmo_access_cycles", 32'(cnt), 32'd256);
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
        chk("tmo_rsp_rdata", rsp_rdata, 32'd0);
        chk("tmo_psel", 32'(PSEL), 32'd0);
        chk("tmo_penable", 32'(PENABLE), 32'd0);
        tick();

        // PREADY on the terminal-count cycle is a normal completion.
        req_valid = 2'b01;
        PRDATA    = 32'hCAFE_F00D;
        PREADY    = 1'b0;
        tick();
        req_valid = 2'b00;
        for (int n = 0; n < 256; n++) begin
            tick();
            if (n == 255) chk("term_still_access", 32'(PENABLE), 32'd1);
            PREADY = (n == 255);
        end
        tick();
        PREADY = 1'b0;
        rd     = 32'hCAFE_F00D;
        chk("term_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("term_rsp_err", 32'(rsp_err), 32'd0);
        chk("term_rsp_rdata", rsp_rdata, rd);
        tick();

        // Reset in the middle of ACCESS aborts silently; the re-issue completes.
        req_addr[1]  = 32'h0000_4000;
        req_wdata[1] = 32'h5555_AAAA;
        req_write    = 2'b10;
        req_valid    = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        chk("rst_mid_penable", 32'(PENABLE), 32'd1);
        PREADY = 1'b1;
        #2 PRESETn = 1'b0;
        #1 chk_all_zero("rst_mid");
        tick();
        tick();
        PRESETn = 1'b1;
        PREADY  = 1'b0;
        tick();
        chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_no_psel", 32'(PSEL), 32'd0);
        run_vec('{valid:2'b10, write:1'b1, addr:32'h0000_4000, wdata:32'hAAAA_5555, prdata:32'hFFFF_0000,
                  waits:0, exp_ready:2'b10, exp_psel:16'h0010, exp_err:1'b0, exp_rdata:32'h0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REQ, default 2, number of requesters.
- NUM_SLV, default 16, number of decoded PSEL bits.
- SEL_LSB, default 12, LSB of the 4-bit slave index field in the address.
- TIMEOUT_CYC, default 256, number of ACCESS cycles without PREADY before abort.

REQ-002 The block SHALL have these ports:
- PCLK  in  1  bus clock; all logic is on its rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted.
- req_addr  in  NUM_REQ x 32  per-requester address.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_wdata  in  NUM_REQ x 32  write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  32  read data, shared, qualified by rsp_valid.
- rsp_err  out  1  timeout or decode error, qualified by rsp_valid.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  16  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-004 In IDLE the block SHALL select one requester with req_valid=1 by round-robin, starting after the last-granted index (index 0 after reset), and SHALL assert req_ready for that requester only, in the same cycle and combinationally from req_valid and the pointer.
REQ-005 On req_valid & req_ready the block SHALL capture addr, write and wdata, record the owner, update the round-robin pointer to the owner and go to SETUP.
REQ-006 Decode: idx = addr[SEL_LSB+3:SEL_LSB]; if idx < NUM_SLV the block SHALL set PSEL[idx]=1, otherwise the transfer is a decode error.
REQ-007 In SETUP the block SHALL drive PSEL one-hot, PENABLE=0 and PADDR/PWRITE/PWDATA from the captured values, then go to ACCESS unconditionally.
REQ-008 In ACCESS the block SHALL hold PENABLE=1 and keep PSEL, PADDR, PWRITE and PWDATA stable until termination.
REQ-009 On PREADY=1 in ACCESS the block SHALL register rsp_valid[owner]=1 for one cycle with rsp_err=0 and rsp_rdata = PRDATA for a read (0 for a write), deassert PSEL and PENABLE, and go to IDLE.
REQ-010 A wait counter SHALL count ACCESS cycles with PREADY=0; when it reaches TIMEOUT_CYC-1 without PREADY, the block SHALL terminate as in REQ-009 with rsp_err=1 and rsp_rdata=0.
REQ-011 PREADY=1 in the same cycle as the counter terminal count SHALL be treated as normal completion, not as a timeout.
REQ-012 On a decode error the block SHALL skip SETUP and ACCESS, keep PSEL all-zero, and assert rsp_valid[owner] with rsp_err=1 in the cycle after acceptance.
REQ-013 The block SHALL have at most one transfer outstanding and SHALL keep req_ready all-zero outside IDLE; back-to-back transfers therefore have at least one IDLE cycle between them.
REQ-014 When PSEL is all-zero, PENABLE SHALL be 0, and PSEL SHALL never be X after reset.
REQ-015 req_valid deasserted before acceptance SHALL be dropped without side effects.

Reset
REQ-016 While PRESETn=0, asynchronously: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, round-robin pointer=0, wait counter=0.
REQ-017 Reset asserted mid-transfer SHALL abort the transfer with no response, and the requester SHALL re-issue it.

Structure
REQ-018 A shared package apb_pkg SHALL hold the state enum, the APB address/data width constants (32) and the PSEL width constant (16).
REQ-019 Round-robin selection SHALL be a sub-module rr_arbiter (NUM_REQ request bits in, one-hot grant out, pointer update input).

Verification
REQ-020 Single write: req0 writes 32'h0000_3004 / 32'hDEAD_BEEF with PREADY=1 -> PSEL=16'h0008, SETUP then ACCESS with PENABLE=1, rsp_valid[0] exactly 2 cycles after acceptance, rsp_err=0.
REQ-021 Wait states: req1 reads 32'h0000_1000 with PREADY low for 3 ACCESS cycles and PRDATA=32'h1234_5678 -> signals stable throughout, rsp_rdata=32'h1234_5678, rsp_valid[1] one cycle after PREADY.
REQ-022 Fairness: both requesters hold req_valid continuously for 4 transfers -> grants alternate 0,1,0,1.
REQ-023 Timeout: PREADY held at 0 -> rsp_err=1 and rsp_rdata=0 after exactly 256 ACCESS cycles, then PSEL=0.
REQ-024 Reset mid-ACCESS: PRESETn pulled low -> all outputs 0 immediately and no rsp_valid; the next request completes normally.
REQ-025 Assertions on every PCLK edge: PSEL not X, PSEL one-hot or zero, PENABLE implies PSEL nonzero.
